or_arbiter: RTL and testbench
=============================

OR_ARBITER -- requirements
Module: or_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 1, operand/result bit width.
REQ-003 SHALL have port CLK  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req_a, req_b  in  NREQ*WIDTH  packed per-requester operands; slice i = [i*WIDTH +: WIDTH].
REQ-006 SHALL have ports req_en  in  NREQ  per-requester request, held until granted; req_rdy  out  NREQ  one-hot grant.
REQ-007 SHALL have ports rsp_data  out  WIDTH, rsp_id  out  $clog2(NREQ), rsp_err  out  1, rsp_rdy  out  1, rsp_en  in  1 (consumer take).
REQ-008 SHALL have OR-unit ports or_a_data, or_b_data  out  WIDTH; or_a_en, or_b_en, or_y_en  out  1; or_a_rdy, or_b_rdy, or_y_rdy  in  1; or_y_data  in  WIDTH.

Function
REQ-009 SHALL implement FSM IDLE -> ISSUE -> COLLECT -> RESP -> IDLE; one transaction in flight.
REQ-010 IDLE: if any req_en, SHALL assert req_rdy[g] combinationally for g = first set req_en after last_grant (round-robin, wrapping NREQ-1 -> 0), latch req_a/req_b slice g and g, go ISSUE; req_rdy all 0 in other states.
REQ-011 ISSUE: SHALL drive latched operands on or_a_data/or_b_data; assert or_a_en and or_b_en in the same cycle only when or_a_rdy && or_b_rdy both 1; then go COLLECT; otherwise hold.
REQ-012 COLLECT: when or_y_rdy=1 SHALL assert or_y_en for exactly one cycle, capture or_y_data into result register, go RESP.
REQ-013 RESP: SHALL hold rsp_rdy=1 with stable rsp_data, rsp_id, rsp_err; on rsp_en=1 update last_grant=rsp_id and go IDLE.
REQ-014 rsp_en while rsp_rdy=0 SHALL be ignored; req_en deassertion before grant SHALL withdraw the request without side effect.
REQ-015 Minimum latency: grant cycle N, OR issue N+1, collect N+2, rsp_rdy N+3; throughput at most one per 4 cycles.
REQ-016 A single active requester SHALL be granted on every IDLE visit (no starvation, no idle gap beyond FSM).

Reset
REQ-017 RST=1 at an edge SHALL force IDLE, last_grant=NREQ-1 (requester 0 first), result/operand registers 0, rsp_err=0.
REQ-018 While in reset and the cycle after, req_rdy, rsp_rdy, or_a_en, or_b_en, or_y_en SHALL be 0.
REQ-019 Reset mid-transaction SHALL drop it silently; no response produced.

Configuration
REQ-020 Macro OR_ARBITER_TIMEOUT_EN defined: a 5-bit counter SHALL count cycles in ISSUE+COLLECT; on reaching 16 the FSM SHALL go RESP with rsp_data=0, rsp_err=1, deasserting all or_*_en.
REQ-021 Macro undefined: no counter; FSM waits indefinitely; rsp_err tied 0.

Structure
REQ-022 Package or_arbiter_pkg SHALL hold state enum (IDLE, ISSUE, COLLECT, RESP) and constant TIMEOUT_CYCLES=16.
REQ-023 Round-robin pick SHALL be sub-module or_rr_pick (inputs req vector, last_grant; outputs grant index, any_req), purely combinational.

Verification
REQ-024 Reset, req_en=4'b0000, OR rdys all 1 -> req_rdy=0, rsp_rdy=0, all or_*_en=0 for 10 cycles.
REQ-025 Req 2 only, a=1,b=0, all rdys 1, rsp_en=1 -> req_rdy=4'b0100 at N, or_a_en/or_b_en at N+1, or_y_en at N+2, rsp_rdy N+3 with rsp_data=1, rsp_id=2.
REQ-026 req_en=4'b1111 held, 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-027 or_b_rdy low 5 cycles in ISSUE -> no or_a_en/or_b_en until both rdy; data unchanged; correct result.
REQ-028 RST pulsed during COLLECT -> IDLE next cycle, no rsp_rdy, next grant to requester 0.
REQ-029 With OR_ARBITER_TIMEOUT_EN, or_y_rdy stuck 0 -> rsp_rdy after 16 cycles, rsp_err=1, rsp_data=0; without macro -> rsp_rdy stays 0.

Source files
------------

// File: rtl/or_arbiter_pkg.sv
// Shared FSM state type and timing constants for the or_arbiter block.
package or_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    COLLECT = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam int TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/or_rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_grant, wrapping.
module or_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_last_grant,
  output logic [$clog2(NREQ)-1:0] o_grant,
  output logic                    o_any_req
);

  localparam int IDW = $clog2(NREQ);

  // Walk offsets from farthest to nearest so the nearest match is the one left standing.
  always_comb begin
    logic [IDW:0] w_idx;
    o_grant   = '0;
    o_any_req = 1'b0;
    w_idx     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = {1'b0, i_last_grant} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NREQ)) begin
        w_idx = w_idx - (IDW+1)'(NREQ);
      end
      if (i_req[w_idx[IDW-1:0]]) begin
        o_grant   = w_idx[IDW-1:0];
        o_any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/or_arbiter.sv
// Round-robin arbiter sharing one external OR unit among NREQ requesters, one transaction in flight.
// Optional macro OR_ARBITER_TIMEOUT_EN adds an ISSUE/COLLECT watchdog that answers with rsp_err=1.
module or_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  input  logic [NREQ-1:0]          req_en,
  output logic [NREQ-1:0]          req_rdy,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     rsp_err,
  output logic                     rsp_rdy,
  input  logic                     rsp_en,
  output logic [WIDTH-1:0]         or_a_data,
  output logic [WIDTH-1:0]         or_b_data,
  output logic                     or_a_en,
  output logic                     or_b_en,
  output logic                     or_y_en,
  input  logic                     or_a_rdy,
  input  logic                     or_b_rdy,
  input  logic                     or_y_rdy,
  input  logic [WIDTH-1:0]         or_y_data
);

  import or_arbiter_pkg::*;

  localparam int IDW = $clog2(NREQ);

  state_t           r_state;
  logic [IDW-1:0]   r_last_grant;
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_rst_q;

  logic             w_quiet;
  logic             w_any;
  logic [IDW-1:0]   w_pick;
  logic             w_grant;
  logic             w_issue;
  logic             w_collect;
  logic             w_timeout;
  logic [WIDTH-1:0] w_a_arr [NREQ];
  logic [WIDTH-1:0] w_b_arr [NREQ];

  or_rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req        (req_en),
    .i_last_grant (r_last_grant),
    .o_grant      (w_pick),
    .o_any_req    (w_any)
  );

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign w_a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
      assign w_b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
      assign req_rdy[gi] = w_grant && (w_pick == IDW'(gi));
    end
  endgenerate

  // All handshake outputs stay low during reset and for the first cycle after it.
  assign w_quiet   = RST | r_rst_q;
  assign w_grant   = (r_state == IDLE) && w_any && !w_quiet;
  assign w_issue   = (r_state == ISSUE) && or_a_rdy && or_b_rdy && !w_timeout && !w_quiet;
  assign w_collect = (r_state == COLLECT) && or_y_rdy && !w_timeout && !w_quiet;

  assign or_a_data = r_a;
  assign or_b_data = r_b;
  assign or_a_en   = w_issue;
  assign or_b_en   = w_issue;
  assign or_y_en   = w_collect;
  assign rsp_rdy   = (r_state == RESP) && !w_quiet;
  assign rsp_data  = r_result;
  assign rsp_id    = r_id;

`ifdef OR_ARBITER_TIMEOUT_EN
  logic [4:0] r_tmo_cnt;
  logic       r_err;

  assign w_timeout = ((r_state == ISSUE) || (r_state == COLLECT)) &&
                     (r_tmo_cnt == 5'(TIMEOUT_CYCLES - 1));
  assign rsp_err   = r_err;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_grant) begin
        r_tmo_cnt <= '0;
        r_err     <= 1'b0;
      end else if ((r_state == ISSUE) || (r_state == COLLECT)) begin
        r_tmo_cnt <= r_tmo_cnt + 5'd1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    r_rst_q <= RST;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_last_grant <= IDW'(NREQ - 1);
      r_id         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_result     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_a     <= w_a_arr[w_pick];
            r_b     <= w_b_arr[w_pick];
            r_id    <= w_pick;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (w_timeout) begin
            r_result <= '0;
            r_state  <= RESP;
          end else if (w_issue) begin
            r_state <= COLLECT;
          end
        end
        COLLECT: begin
          if (w_timeout) begin
            r_result <= '0;
            r_state  <= RESP;
          end else if (w_collect) begin
            r_result <= or_y_data;
            r_state  <= RESP;
          end
        end
        RESP: begin
          if (rsp_en) begin
            r_last_grant <= r_id;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_or_arbiter.sv
// Randomized self-checking bench for or_arbiter; the bench itself plays the OR unit and the consumer.
module tb_or_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_en = '0;
  logic [NREQ-1:0]   req_rdy;
  logic [W-1:0]      rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_err;
  logic              rsp_rdy;
  logic              rsp_en = 1'b0;
  logic [W-1:0]      or_a_data;
  logic [W-1:0]      or_b_data;
  logic              or_a_en;
  logic              or_b_en;
  logic              or_y_en;
  logic              or_a_rdy = 1'b1;
  logic              or_b_rdy = 1'b1;
  logic              or_y_rdy = 1'b1;
  logic [W-1:0]      or_y_data = '0;

  logic [NREQ+3:0]   outs;
  int                n_tests = 0;
  int                n_fail = 0;
  int                m_last;
  int                gid;

  assign outs = {req_rdy, rsp_rdy, or_a_en, or_b_en, or_y_en};

  always #5 CLK = ~CLK;

  or_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_en    (req_en),
    .req_rdy   (req_rdy),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .rsp_rdy   (rsp_rdy),
    .rsp_en    (rsp_en),
    .or_a_data (or_a_data),
    .or_b_data (or_b_data),
    .or_a_en   (or_a_en),
    .or_b_en   (or_b_en),
    .or_y_en   (or_y_en),
    .or_a_rdy  (or_a_rdy),
    .or_b_rdy  (or_b_rdy),
    .or_y_rdy  (or_y_rdy),
    .or_y_data (or_y_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge CLK);
    #1;
  endtask

  // Reference: first requester after the last served one, counting upward with wrap.
  function automatic int model_pick(input logic [NREQ-1:0] en, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (en[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = W'($urandom);
      req_b[i*W +: W] = W'($urandom);
    end
  endtask

  // mode 0: all ready, mode 1: random stalls (bounded), mode 2: or_b_rdy low for 5 ISSUE cycles.
  task automatic txn(input logic [NREQ-1:0] en, input int mode, input int exp_wait, output int g);
    int           n;
    int           hold;
    bit           done;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic [W-1:0] y_cap;
    logic [W-1:0] got;
    req_en   = en;
    g        = model_pick(en, m_last);
    ea       = req_a[g*W +: W];
    eb       = req_b[g*W +: W];
    y_cap    = '0;
    or_a_rdy = 1'b1;
    or_b_rdy = 1'b1;
    or_y_rdy = 1'b1;
    rsp_en   = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    n = 0;
    #1;
    chk("rsp_rdy_idle", 32'(rsp_rdy), 0);
    while (req_rdy == '0 && n < 20) begin
      next_cyc();
      n++;
      #1;
    end
    chk("grant", 32'(req_rdy), 32'(1 << g));
    if (exp_wait >= 0) chk("grant_wait", n, exp_wait);
    next_cyc();

    n = 0;
    done = 1'b0;
    while (!done && n < 30) begin
      if (mode == 1) begin
        or_a_rdy = (n >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
        or_b_rdy = (n >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
        rsp_en   = 1'($urandom_range(0, 1));
      end else if (mode == 2) begin
        or_a_rdy = 1'b1;
        or_b_rdy = (n >= 5);
      end
      #1;
      chk("issue_en_a", 32'(or_a_en), 32'(or_a_rdy & or_b_rdy));
      chk("issue_en_b", 32'(or_b_en), 32'(or_a_rdy & or_b_rdy));
      chk("a_data", 32'(or_a_data), 32'(ea));
      chk("b_data", 32'(or_b_data), 32'(eb));
      chk("busy_no_grant", 32'(req_rdy), 0);
      if (or_a_en && or_b_en) begin
        done  = 1'b1;
        y_cap = or_a_data | or_b_data;
      end
      next_cyc();
      n++;
    end
    chk("issue_done", 32'(done), 1);
    if (mode == 0) chk("issue_lat", n, 1);
    if (mode == 2) chk("issue_stall_lat", n, 6);
    or_a_rdy = 1'b1;
    or_b_rdy = 1'b1;

    n = 0;
    done = 1'b0;
    while (!done && n < 30) begin
      or_y_rdy  = (mode == 1 && n < 4) ? 1'($urandom_range(0, 1)) : 1'b1;
      or_y_data = or_y_rdy ? y_cap : ~y_cap;
      if (mode == 1) rsp_en = 1'($urandom_range(0, 1));
      #1;
      chk("y_en", 32'(or_y_en), 32'(or_y_rdy));
      chk("no_reissue", 32'({or_a_en, or_b_en}), 0);
      chk("rsp_rdy_busy", 32'(rsp_rdy), 0);
      if (or_y_en) done = 1'b1;
      next_cyc();
      n++;
    end
    chk("collect_done", 32'(done), 1);
    if (mode != 1) chk("collect_lat", n, 1);
    or_y_data = '0;

    hold = (mode == 1) ? $urandom_range(0, 2) : 0;
    got  = '0;
    for (int h = 0; h <= hold; h++) begin
      rsp_en = (h == hold);
      #1;
      chk("rsp_rdy", 32'(rsp_rdy), 1);
      chk("rsp_data", 32'(rsp_data), 32'(ea | eb));
      chk("rsp_id", 32'(rsp_id), 32'(g));
      chk("rsp_err", 32'(rsp_err), 0);
      chk("resp_quiet", 32'({req_rdy, or_a_en, or_b_en, or_y_en}), 0);
      got = rsp_data;
      next_cyc();
    end
    rsp_en = 1'b0;
    m_last = g;
    $display("[TB] txn id=%0d a=%0h b=%0h rsp=%0h", g, ea, eb, got);
  endtask

  initial begin
    int g;
    int n;
    m_last = NREQ - 1;

    repeat (3) begin
      next_cyc();
      chk("rst_quiet", 32'(outs), 0);
      chk("rst_data", 32'({rsp_data, or_a_data, or_b_data, rsp_err}), 0);
    end
    RST = 1'b0;
    #1;
    chk("post_rst_quiet", 32'(outs), 0);
    for (int i = 0; i < 10; i++) begin
      next_cyc();
      chk("idle_quiet", 32'(outs), 0);
    end

    for (int i = 0; i < 8; i++) begin
      rand_ops();
      txn(4'b1111, 0, 0, gid);
      chk("rr_order", gid, i % 4);
    end

    rand_ops();
    req_a[2*W +: W] = W'(1);
    req_b[2*W +: W] = W'(0);
    txn(4'b0100, 0, 0, gid);

    for (int i = 0; i < 3; i++) begin
      rand_ops();
      txn(4'b0010, (i == 1) ? 1 : 0, 0, gid);
    end

    rand_ops();
    txn(4'b0100, 2, 0, gid);

    for (int i = 0; i < 30; i++) begin
      rand_ops();
      txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 1, 0, gid);
    end

    // Reset in the middle of COLLECT: nothing is answered and requester 0 is next.
    rand_ops();
    txn(4'b0001, 0, 0, gid);
    rand_ops();
    req_en   = 4'b1111;
    or_y_rdy = 1'b0;
    g = model_pick(req_en, m_last);
    #1;
    chk("grant_pre_rst", 32'(req_rdy), 32'(1 << g));
    next_cyc();
    #1;
    chk("issue_pre_rst", 32'(or_a_en & or_b_en), 1);
    next_cyc();
    #1;
    chk("collect_hold", 32'(or_y_en), 0);
    RST      = 1'b1;
    or_y_rdy = 1'b1;
    #1;
    chk("rst_mid_quiet", 32'(outs), 0);
    next_cyc();
    RST    = 1'b0;
    m_last = NREQ - 1;
    rand_ops();
    txn(4'b1111, 0, 1, gid);
    chk("post_rst_grant", gid, 0);

    // OR result never arrives.
    rand_ops();
    req_en   = 4'b0001;
    or_y_rdy = 1'b0;
    g = model_pick(req_en, m_last);
    #1;
    chk("grant_stuck", 32'(req_rdy), 32'(1 << g));
    next_cyc();
    n = 1;
    #1;
    while (!rsp_rdy && n < 40) begin
      next_cyc();
      #1;
      n++;
    end
`ifdef OR_ARBITER_TIMEOUT_EN
    chk("tmo_lat", n, 17);
    chk("tmo_rsp_rdy", 32'(rsp_rdy), 1);
    chk("tmo_err", 32'(rsp_err), 1);
    chk("tmo_data", 32'(rsp_data), 0);
    chk("tmo_id", 32'(rsp_id), 32'(g));
    rsp_en = 1'b1;
    next_cyc();
    rsp_en = 1'b0;
    m_last = g;
    $display("[TB] txn id=%0d timed out", g);
`else
    chk("no_tmo_rsp", 32'(rsp_rdy), 0);
    chk("no_tmo_err", 32'(rsp_err), 0);
    RST = 1'b1;
    next_cyc();
    RST    = 1'b0;
    m_last = NREQ - 1;
    next_cyc();
`endif
    or_y_rdy = 1'b1;
    req_en   = '0;
    next_cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
